branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
// Consumer of the execute-stage ALU's branch-condition output: turns a resolved taken branch/jump
// into a PC redirect for fetch, plus flushes of the wrong-path IF/ID and ID/EX instructions.
// Static predict-not-taken. Holds the redirect while fetch is stalled on instruction memory.
// Keeps saturating branch statistics for performance debug.
// PARAMETERS
// CNT_W  16  width of the saturating statistics counters
// PORTS
// clk            in   1      system clock, rising edge
// rst_n          in   1      asynchronous active-low reset
// ex_valid       in   1      EX stage holds a valid instruction
// ex_stall       in   1      EX stage frozen this cycle; no resolution allowed
// ex_is_branch   in   1      EX instruction is a conditional branch
// ex_is_jump     in   1      EX instruction is an unconditional jump (J/JAL/JR/JALR)
// ex_branch_con  in   1      condition result from the execute-stage ALU (1 = taken)
// ex_target      in   16     computed branch/jump target
// fetch_stall    in   1      instruction memory not ready; fetch cannot accept a new PC
// redirect_valid out  1      fetch must load redirect_pc
// redirect_pc    out  16     redirect address, bit 0 always 0
// flush_ifid     out  1      kill the IF/ID instruction (write NOP)
// flush_idex     out  1      kill the ID/EX instruction (write NOP)
// br_total_cnt   out  CNT_W  resolved branches+jumps, saturating
// br_taken_cnt   out  CNT_W  taken branches+jumps, saturating
// err            out  1      sticky decode/target fault
// BEHAVIOUR
// - resolve = ex_valid & ~ex_stall & (state==IDLE); take = resolve & (ex_is_jump | ex_is_branch & ex_branch_con)
// - Reset (async, rst_n=0): state=IDLE, tgt_q=0, redirect_valid=0, redirect_pc=0, flush_*=0, counters=0, err=0
// - States: IDLE, REDIR
// - IDLE: take -> latch tgt_q={ex_target[15:1],1'b0}; assert flush_ifid and flush_idex combinationally
//   in the same cycle (Mealy); next=REDIR. No take -> stay IDLE, flushes 0.
// - REDIR: redirect_valid=1, redirect_pc=tgt_q (both registered, visible the cycle after take).
//   flush_ifid=1 every REDIR cycle. fetch_stall=1 -> stay REDIR, hold tgt_q; fetch_stall=0 -> IDLE next.
//   Latency take->redirect_valid: exactly 1 cycle; redirect duration: 1 + stalled cycles.
// - ex_valid in REDIR = wrong-path instruction: flush_idex=1, not resolved, not counted.
// - ex_stall=1 suppresses resolve; the instruction resolves on the first unstalled cycle (counted once).
// - ex_is_branch & ex_branch_con=0: not taken, no flush, no redirect; total counter only.
// - Counters: resolve & (ex_is_branch|ex_is_jump) -> br_total_cnt+1; take -> br_taken_cnt+1;
//   both saturate at all-ones and never wrap.
// - err set (sticky until reset) when resolve & ex_is_branch & ex_is_jump (treated as jump) or
//   take & ex_target[0]=1 (redirect still performed with bit 0 forced 0).
// - redirect_pc outside REDIR: holds last tgt_q (0 after reset); consumers qualify with redirect_valid.
// - Reset asserted in REDIR: redirect dropped immediately (async), no redirect after release.
// TESTING
// - Jump at tgt 0x0040, fetch_stall=0 -> flush_ifid/idex=1 in take cycle; next cycle redirect_valid=1,
//   pc=0x0040, flush_ifid=1; following cycle IDLE, all 0; total=1, taken=1
// - Branch with ex_branch_con=0 -> no flush/redirect; total=1, taken=0
// - Taken branch tgt 0x1234 with fetch_stall=1 for 3 cycles -> redirect_valid held 4 cycles,
//   pc stays 0x1234; ex_valid pulsed during REDIR -> flush_idex=1, counters unchanged
// - ex_stall=1 for 2 cycles on taken branch -> no action until stall drops; taken counted once
// - ex_is_branch & ex_is_jump, tgt 0x0011 -> err=1 sticky, redirect_pc=0x0010; CNT_W=4 preload
//   15 takes then 2 more -> both counters hold 4'hF
// - rst_n low mid-REDIR -> redirect_valid/flushes/err/counters 0 asynchronously; IDLE after release

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect controller: turns a resolved taken branch or jump in EX
// into a fetch PC redirect plus wrong-path flushes, holding the redirect while
// fetch is stalled. Keeps saturating branch statistics and a sticky fault flag.
module branch_redirect_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_branch_con,
  input  logic [15:0]      ex_target,
  input  logic             fetch_stall,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] br_total_cnt,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic             err
);

  typedef enum logic {
    IDLE,
    REDIR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] tgt_q;
  logic        resolve;
  logic        take;
  logic        is_ctrl;

  assign is_ctrl = ex_is_branch | ex_is_jump;
  assign resolve = ex_valid & ~ex_stall & (state == IDLE);
  assign take    = resolve & (ex_is_jump | (ex_is_branch & ex_branch_con));

  assign redirect_valid = (state == REDIR);
  assign redirect_pc    = tgt_q;

  // Next-state and flush decode; flushes are held low while reset is asserted
  always_comb begin
    state_nxt  = state;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_nxt  = REDIR;
        end
      end
      REDIR: begin
        flush_ifid = 1'b1;
        flush_idex = ex_valid;
        if (!fetch_stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect target capture with bit 0 forced low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= '0;
    end else if (take) begin
      tgt_q <= {ex_target[15:1], 1'b0};
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_total_cnt <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (resolve && is_ctrl && (br_total_cnt != '1)) begin
        br_total_cnt <= br_total_cnt + CNT_W'(1);
      end
      if (take && (br_taken_cnt != '1)) begin
        br_taken_cnt <= br_taken_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky fault: ambiguous branch+jump decode or misaligned taken target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((resolve && ex_is_branch && ex_is_jump) || (take && ex_target[0])) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a stimulus process drives one
// cycle at a time and queues the expected outputs from a reference model; a
// monitor process pops and compares on every falling edge.
module tb_branch_redirect_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_stall;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             ex_branch_con;
  logic [15:0]      ex_target;
  logic             fetch_stall;
  logic             redirect_valid;
  logic [15:0]      redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic [CNT_W-1:0] br_total_cnt;
  logic [CNT_W-1:0] br_taken_cnt;
  logic             err;

  branch_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_branch_con  (ex_branch_con),
    .ex_target      (ex_target),
    .fetch_stall    (fetch_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .br_total_cnt   (br_total_cnt),
    .br_taken_cnt   (br_taken_cnt),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [15:0] pc;
    logic        fi;
    logic        fd;
    int unsigned tot;
    int unsigned tkn;
    logic        er;
  } exp_t;

  exp_t q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: pending redirect and its target, plain-integer counters
  bit          m_busy = 1'b0;
  logic [15:0] m_tgt  = '0;
  int unsigned m_tot  = 0;
  int unsigned m_tkn  = 0;
  bit          m_err  = 1'b0;
  int unsigned sat_max = (1 << CNT_W) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; expected outputs for this cycle go to the queue
  task automatic cyc(input bit rst, input bit v, input bit st, input bit b, input bit j,
                     input bit c, input logic [15:0] tgt, input bit fs);
    exp_t e;
    bit res, tk;
    @(posedge clk);
    #1;
    rst_n = rst; ex_valid = v; ex_stall = st; ex_is_branch = b; ex_is_jump = j;
    ex_branch_con = c; ex_target = tgt; fetch_stall = fs;
    if (!rst) begin
      m_busy = 0; m_tgt = '0; m_tot = 0; m_tkn = 0; m_err = 0;
      e = '{rv: 0, pc: 16'h0, fi: 0, fd: 0, tot: 0, tkn: 0, er: 0};
      q.push_back(e);
      return;
    end
    res = v && !st && !m_busy;
    tk  = res && (j || (b && c));
    e.rv = m_busy; e.pc = m_tgt; e.fi = tk || m_busy; e.fd = tk || (m_busy && v);
    e.tot = m_tot; e.tkn = m_tkn; e.er = m_err;
    q.push_back(e);
    if ((res && b && j) || (tk && tgt[0])) m_err = 1;
    if (res && (b || j) && m_tot < sat_max) m_tot++;
    if (tk && m_tkn < sat_max) m_tkn++;
    if (m_busy) m_busy = fs;
    else if (tk) begin
      m_busy = 1;
      m_tgt  = tgt & 16'hFFFE;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 16'h0, 0);
  endtask

  // Monitor: compare every presented output cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      chk("redirect_pc",    32'(redirect_pc),    32'(e.pc));
      chk("flush_ifid",     32'(flush_ifid),     32'(e.fi));
      chk("flush_idex",     32'(flush_idex),     32'(e.fd));
      chk("br_total_cnt",   32'(br_total_cnt),   e.tot);
      chk("br_taken_cnt",   32'(br_taken_cnt),   e.tkn);
      chk("err",            32'(err),            32'(e.er));
    end
  end

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jump = 0;
    ex_branch_con = 0; ex_target = '0; fetch_stall = 0;

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc(0, 1, 0, 0, 1, 0, 16'hFFFF, 0);
    idle(1);

    // Jump, no fetch stall
    cyc(1, 1, 0, 0, 1, 0, 16'h0040, 0);
    idle(2);

    // Not-taken branch
    cyc(1, 1, 0, 1, 0, 0, 16'h0099, 0);
    idle(1);

    // Taken branch held by fetch stall; wrong-path instruction during redirect
    cyc(1, 1, 0, 1, 0, 1, 16'h1234, 1);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 1);
    cyc(1, 1, 0, 0, 1, 0, 16'h0500, 1);
    cyc(1, 1, 0, 1, 0, 1, 16'h0600, 1);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 0);
    idle(1);

    // EX stall delays resolution of a taken branch
    cyc(1, 1, 1, 1, 0, 1, 16'h0200, 0);
    cyc(1, 1, 1, 1, 0, 1, 16'h0200, 0);
    cyc(1, 1, 0, 1, 0, 1, 16'h0200, 0);
    idle(2);

    // Ambiguous decode with misaligned target
    cyc(1, 1, 0, 1, 1, 0, 16'h0011, 0);
    idle(2);

    // Saturation of both counters
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 0);
    for (int unsigned i = 0; i < 17; i++) begin
      cyc(1, 1, 0, 0, 1, 0, 16'(i * 4), 0);
      cyc(1, 0, 0, 0, 0, 0, 16'h0, 0);
    end
    idle(1);

    // Reset asserted in the middle of a redirect
    cyc(1, 1, 0, 0, 1, 0, 16'h0ABC, 1);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 1);
    cyc(0, 1, 0, 0, 1, 0, 16'h0777, 1);
    idle(2);

    // Randomized traffic with occasional resets
    for (int unsigned i = 0; i < 600; i++) begin
      cyc(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
          ($urandom % 2) == 1, ($urandom % 3) == 0, ($urandom % 2) == 1,
          16'($urandom), ($urandom % 3) == 0);
    end
    idle(1);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
